// File: rtl/sico_pwm_dac.sv
// Dual-channel PWM DAC for sine_cos samples: converts two's-complement samples to offset-binary duty
// and emits a once-per-frame sample_en strobe that advances the upstream oscillator.
module sico_pwm_dac #(
  parameter int WIDTH    = 8,
  parameter int PRESCALE = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [WIDTH-1:0] sine,
  input  logic [WIDTH-1:0] cos,
  output logic             sample_en,
  output logic             pwm_sin,
  output logic             pwm_cos,
  output logic [WIDTH-1:0] duty_sin,
  output logic [WIDTH-1:0] duty_cos
);

  localparam int               PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0]    PRE_LAST = PW'(PRESCALE - 1);
  localparam logic [WIDTH-1:0] CNT_LAST = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] DUTY_MID = {1'b1, {(WIDTH-1){1'b0}}};

  function automatic logic [WIDTH-1:0] to_offset_bin(input logic [WIDTH-1:0] s);
    return {~s[WIDTH-1], s[WIDTH-2:0]};
  endfunction

  logic [PW-1:0]    pre_cnt_q, pre_cnt_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] duty_sin_q, duty_sin_d;
  logic [WIDTH-1:0] duty_cos_q, duty_cos_d;
  logic             pwm_sin_q, pwm_sin_d;
  logic             pwm_cos_q, pwm_cos_d;
  logic             tick_s;
  logic             frame_end_s;

  // Reset gates the strobe so it never announces a duty load that reset will suppress.
  always_comb begin
    tick_s      = enable & (pre_cnt_q == PRE_LAST);
    frame_end_s = ~reset & tick_s & (cnt_q == CNT_LAST);
  end

  // Next-state: prescaler, frame counter, frame-aligned duty load, PWM compare.
  always_comb begin
    pre_cnt_d  = pre_cnt_q;
    cnt_d      = cnt_q;
    duty_sin_d = duty_sin_q;
    duty_cos_d = duty_cos_q;
    pwm_sin_d  = 1'b0;
    pwm_cos_d  = 1'b0;
    if (!enable) begin
      pre_cnt_d = {PW{1'b0}};
      cnt_d     = {WIDTH{1'b0}};
    end else begin
      if (pre_cnt_q == PRE_LAST) begin
        pre_cnt_d = {PW{1'b0}};
      end else begin
        pre_cnt_d = pre_cnt_q + PW'(1);
      end
      if (tick_s) begin
        cnt_d = cnt_q + WIDTH'(1);
      end else begin
        cnt_d = cnt_q;
      end
      // Duty only changes on the frame boundary, alongside the upstream sample update.
      if (frame_end_s) begin
        duty_sin_d = to_offset_bin(sine);
        duty_cos_d = to_offset_bin(cos);
      end else begin
        duty_sin_d = duty_sin_q;
        duty_cos_d = duty_cos_q;
      end
      pwm_sin_d = (cnt_q < duty_sin_q);
      pwm_cos_d = (cnt_q < duty_cos_q);
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      pre_cnt_q  <= {PW{1'b0}};
      cnt_q      <= {WIDTH{1'b0}};
      duty_sin_q <= DUTY_MID;
      duty_cos_q <= DUTY_MID;
      pwm_sin_q  <= 1'b0;
      pwm_cos_q  <= 1'b0;
    end else begin
      pre_cnt_q  <= pre_cnt_d;
      cnt_q      <= cnt_d;
      duty_sin_q <= duty_sin_d;
      duty_cos_q <= duty_cos_d;
      pwm_sin_q  <= pwm_sin_d;
      pwm_cos_q  <= pwm_cos_d;
    end
  end

  assign sample_en = frame_end_s;
  assign pwm_sin   = pwm_sin_q;
  assign pwm_cos   = pwm_cos_q;
  assign duty_sin  = duty_sin_q;
  assign duty_cos  = duty_cos_q;

endmodule
